// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard/forwarding bundle between ID stage and scoreboard.
// master = decode stage (drives ID fields), slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_W = 4,
  parameter int SEL_W = 3
);
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic [REG_W-1:0] id_dest;
  logic             id_wb_en;
  logic             id_mem_r_en;
  logic             flush;
  logic             stall;
  logic [SEL_W-1:0] fwd_sel1;
  logic [SEL_W-1:0] fwd_sel2;
  logic [31:0]      stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src,
    output id_dest, id_wb_en, id_mem_r_en, flush,
    input  stall, fwd_sel1, fwd_sel2, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src,
    input  id_dest, id_wb_en, id_mem_r_en, flush,
    output stall, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift scoreboard of in-flight destinations (EX..WB) resolving ID sources
// into forwarding selects or a stall; ports: clk, rst, hz (slave bundle).
module hazard_scoreboard #(
  parameter int REG_W  = 4,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int SEL_W  = 3
) (
  input  logic clk,
  input  logic rst,
  hazard_scoreboard_if.slave hz
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] ld_q;
  logic [REG_W-1:0] dst_q [DEPTH];
  logic [31:0]      cnt_q;

  logic [DEPTH-1:0] m1;
  logic [DEPTH-1:0] m2;
  logic [SEL_W-1:0] s1;
  logic [SEL_W-1:0] s2;
  logic             hazard;
  logic             stall;
  logic             ins;

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m1[k] = hz.id_valid & v_q[k] & (dst_q[k] == hz.id_src1);
      m2[k] = hz.id_valid & hz.id_two_src & v_q[k] &
              (dst_q[k] == hz.id_src2);
    end
  end

  // Scan oldest to youngest so the youngest producer wins.
  always_comb begin
    s1 = '0;
    s2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (m1[k]) s1 = SEL_W'(k + 1);
      if (m2[k]) s2 = SEL_W'(k + 1);
    end
  end

  // Entry 0 is the youngest, so a hit there always wins the priority.
  always_comb begin
    hazard      = 1'b0;
    hz.fwd_sel1 = '0;
    hz.fwd_sel2 = '0;
    if (FWD_EN != 0) begin
      hazard      = (m1[0] | m2[0]) & ld_q[0];
      hz.fwd_sel1 = s1;
      hz.fwd_sel2 = s2;
    end else begin
      hazard = (|m1) | (|m2);
    end
  end

  assign stall        = hazard & ~hz.flush;
  assign ins          = ~(stall | hz.flush);
  assign hz.stall     = stall;
  assign hz.stall_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int k = 0; k < DEPTH; k++) dst_q[k] <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        v_q[k]   <= v_q[k-1];
        ld_q[k]  <= ld_q[k-1];
        dst_q[k] <= dst_q[k-1];
      end
      v_q[0]   <= ins & hz.id_valid & hz.id_wb_en;
      ld_q[0]  <= ins & hz.id_mem_r_en;
      dst_q[0] <= hz.id_dest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall && cnt_q != 32'hFFFF_FFFF) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one forwarding instance and one
// stall-only instance driven with the same decode stream.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(4), .SEL_W(3)) f_if ();
  hazard_scoreboard_if #(.REG_W(4), .SEL_W(3)) s_if ();

  hazard_scoreboard #(.REG_W(4), .DEPTH(3), .FWD_EN(1), .SEL_W(3))
    dut_f (.clk(clk), .rst(rst), .hz(f_if));

  hazard_scoreboard #(.REG_W(4), .DEPTH(3), .FWD_EN(0), .SEL_W(3))
    dut_s (.clk(clk), .rst(rst), .hz(s_if));

  task automatic drive(input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic two,
                       input logic [3:0] d, input logic wb,
                       input logic ld, input logic fl);
    f_if.id_valid = v;   s_if.id_valid = v;
    f_if.id_src1 = a;    s_if.id_src1 = a;
    f_if.id_src2 = b;    s_if.id_src2 = b;
    f_if.id_two_src = two; s_if.id_two_src = two;
    f_if.id_dest = d;    s_if.id_dest = d;
    f_if.id_wb_en = wb;  s_if.id_wb_en = wb;
    f_if.id_mem_r_en = ld; s_if.id_mem_r_en = ld;
    f_if.flush = fl;     s_if.flush = fl;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled at the falling edge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    checks++;
    if (f_if.stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b exp 0", f_if.stall);
    end
    checks++;
    if (f_if.fwd_sel1 !== 3'd0 || f_if.fwd_sel2 !== 3'd0) begin
      errors++; $display("FAIL reset_sel got %0d/%0d exp 0/0",
                         f_if.fwd_sel1, f_if.fwd_sel2);
    end
    checks++;
    if (f_if.stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0h exp 0", f_if.stall_cnt);
    end
    tick();
    rst = 1'b0;
    drive(1, 3, 3, 1, 0, 0, 0, 0);
    settle();
    checks++;
    if (f_if.stall !== 1'b0 || f_if.fwd_sel1 !== 3'd0) begin
      errors++; $display("FAIL empty_probe got stall=%b sel1=%0d exp 0/0",
                         f_if.stall, f_if.fwd_sel1);
    end
    checks++;
    if (s_if.stall !== 1'b0) begin
      errors++; $display("FAIL empty_probe_s got %b exp 0", s_if.stall);
    end
  endtask

  task automatic test_forward();
    do_reset();
    drive(1, 2, 3, 1, 1, 1, 0, 0);
    settle();
    checks++;
    if (f_if.stall !== 1'b0) begin
      errors++; $display("FAIL fwd_add_stall got %b exp 0", f_if.stall);
    end
    tick();
    drive(1, 1, 1, 1, 2, 1, 0, 0);
    settle();
    checks++;
    if (f_if.stall !== 1'b0 || f_if.fwd_sel1 !== 3'd1 ||
        f_if.fwd_sel2 !== 3'd1) begin
      errors++; $display("FAIL fwd_sub got stall=%b sel=%0d/%0d exp 0/1/1",
                         f_if.stall, f_if.fwd_sel1, f_if.fwd_sel2);
    end
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    settle();
    checks++;
    if (f_if.fwd_sel1 !== 3'd2) begin
      errors++; $display("FAIL fwd_second got %0d exp 2", f_if.fwd_sel1);
    end
    tick();
    drive(1, 1, 2, 1, 0, 0, 0, 0);
    settle();
    checks++;
    if (f_if.fwd_sel1 !== 3'd3 || f_if.fwd_sel2 !== 3'd2 ||
        f_if.stall !== 1'b0) begin
      errors++; $display("FAIL fwd_third got sel=%0d/%0d stall=%b exp 3/2/0",
                         f_if.fwd_sel1, f_if.fwd_sel2, f_if.stall);
    end
    tick();
    drive(1, 1, 2, 1, 0, 0, 0, 0);
    settle();
    checks++;
    if (f_if.fwd_sel1 !== 3'd0 || f_if.fwd_sel2 !== 3'd3) begin
      errors++; $display("FAIL fwd_fourth got sel=%0d/%0d exp 0/3",
                         f_if.fwd_sel1, f_if.fwd_sel2);
    end
    checks++;
    if (s_if.fwd_sel1 !== 3'd0 || s_if.fwd_sel2 !== 3'd0) begin
      errors++; $display("FAIL stall_only_sel got %0d/%0d exp 0/0",
                         s_if.fwd_sel1, s_if.fwd_sel2);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 5, 0, 0, 4, 1, 1, 0);
    tick();
    drive(1, 4, 0, 0, 5, 1, 0, 0);
    settle();
    checks++;
    if (f_if.stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall got %b exp 1", f_if.stall);
    end
    tick();
    settle();
    checks++;
    if (f_if.stall !== 1'b0 || f_if.fwd_sel1 !== 3'd2) begin
      errors++; $display("FAIL lu_after got stall=%b sel1=%0d exp 0/2",
                         f_if.stall, f_if.fwd_sel1);
    end
    checks++;
    if (f_if.stall_cnt !== 32'd1) begin
      errors++; $display("FAIL lu_cnt got %0d exp 1", f_if.stall_cnt);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    checks++;
    if (f_if.stall_cnt !== 32'd1) begin
      errors++; $display("FAIL lu_cnt_hold got %0d exp 1", f_if.stall_cnt);
    end
  endtask

  task automatic test_stall_only();
    do_reset();
    drive(1, 2, 3, 1, 1, 1, 0, 0);
    tick();
    drive(1, 1, 0, 0, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (s_if.stall !== 1'b1) begin
        errors++; $display("FAIL so_stall%0d got %b exp 1", i, s_if.stall);
      end
      tick();
    end
    settle();
    checks++;
    if (s_if.stall !== 1'b0 || s_if.fwd_sel1 !== 3'd0) begin
      errors++; $display("FAIL so_release got stall=%b sel1=%0d exp 0/0",
                         s_if.stall, s_if.fwd_sel1);
    end
    checks++;
    if (s_if.stall_cnt !== 32'd3) begin
      errors++; $display("FAIL so_cnt got %0d exp 3", s_if.stall_cnt);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 6, 0, 0, 4, 1, 1, 0);
    tick();
    drive(1, 4, 0, 0, 5, 1, 0, 1);
    settle();
    checks++;
    if (f_if.stall !== 1'b0) begin
      errors++; $display("FAIL fl_stall got %b exp 0", f_if.stall);
    end
    tick();
    drive(1, 5, 4, 1, 0, 0, 0, 0);
    settle();
    checks++;
    if (f_if.fwd_sel1 !== 3'd0 || f_if.fwd_sel2 !== 3'd2 ||
        f_if.stall !== 1'b0) begin
      errors++; $display("FAIL fl_bubble got sel=%0d/%0d stall=%b exp 0/2/0",
                         f_if.fwd_sel1, f_if.fwd_sel2, f_if.stall);
    end
    checks++;
    if (f_if.stall_cnt !== 32'd0) begin
      errors++; $display("FAIL fl_cnt got %0d exp 0", f_if.stall_cnt);
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1, 15, 0, 0, 15, 1, 0, 0);
    tick();
    drive(1, 15, 0, 0, 2, 1, 0, 0);
    settle();
    force dut_s.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut_s.cnt_q;
    checks++;
    if (s_if.stall !== 1'b1 || s_if.stall_cnt !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL sat_pre got stall=%b cnt=%0h exp 1/fffffffe",
                         s_if.stall, s_if.stall_cnt);
    end
    tick();
    settle();
    checks++;
    if (s_if.stall_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sat_top got %0h exp ffffffff", s_if.stall_cnt);
    end
    tick();
    settle();
    checks++;
    if (s_if.stall_cnt !== 32'hFFFF_FFFF || s_if.stall !== 1'b1) begin
      errors++; $display("FAIL sat_hold got cnt=%0h stall=%b exp ffffffff/1",
                         s_if.stall_cnt, s_if.stall);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (s_if.stall !== 1'b0 || s_if.stall_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_mid got stall=%b cnt=%0h exp 0/0",
                         s_if.stall, s_if.stall_cnt);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_stall_only();
    test_flush();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
